// File: rtl/ame_approx_arb.sv
// Round-robin front end sharing one leading-one approximator among requesters.
// Each requester has one outstanding operation and a result slot held until consumed.
`timescale 1ns/1ps

module ame_num_approx #(
    parameter int DATA_BITS = 64,
    parameter int RES_BITS  = $clog2(DATA_BITS)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 comp_init_i,
    input  logic [DATA_BITS-1:0] comp_data_i,
    output logic [RES_BITS-1:0]  comp_data_o
);
    logic [DATA_BITS-1:0] mag;
    logic [RES_BITS-1:0]  pos;

    // the most negative value negates to itself, which reads as 2^(DATA_BITS-1)
    assign mag = comp_data_i[DATA_BITS-1] ? (-comp_data_i) : comp_data_i;

    always_comb begin
        pos = '0;
        for (int b = 0; b < DATA_BITS; b++) begin
            if (mag[b]) pos = RES_BITS'(b);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            comp_data_o <= '0;
        end else if (comp_init_i) begin
            comp_data_o <= pos;
        end
    end
endmodule

module ame_approx_arb #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 64,
    parameter int RES_BITS  = $clog2(DATA_BITS)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_BITS-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    input  logic [NUM_REQ-1:0]            rsp_ready_i,
    output logic [NUM_REQ*RES_BITS-1:0]   rsp_data_o,
    output logic [NUM_REQ-1:0]            rsp_zero_o,
    output logic                          busy_o
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0][DATA_BITS-1:0] ops;
    logic [NUM_REQ-1:0][RES_BITS-1:0]  slot_data;
    logic [NUM_REQ-1:0]                slot_zero;
    logic [NUM_REQ-1:0]                rsp_valid_q;
    logic [NUM_REQ-1:0]                busy_q;
    logic [NUM_REQ-1:0]                busy_d;
    logic [NUM_REQ-1:0]                elig;
    logic [NUM_REQ-1:0]                grant;
    logic [NUM_REQ-1:0]                consume;
    logic [PW-1:0]                     ptr_q;
    logic [PW-1:0]                     gidx;
    logic                              found;
    logic                              run_q;
    logic                              busy_q_out;

    logic                              inflight_v;
    logic [PW-1:0]                     inflight_tag;
    logic                              inflight_zero;

    logic                              comp_init;
    logic [DATA_BITS-1:0]              comp_data;
    logic [RES_BITS-1:0]               comp_res;

    assign ops = req_data_i;

    // run_q keeps grants off until the first clock after reset release
    assign elig = req_valid_i & ~busy_q & {NUM_REQ{run_q}};

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && elig[(int'(ptr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                gidx  = PW'((int'(ptr_q) + k) % NUM_REQ);
                grant[(int'(ptr_q) + k) % NUM_REQ] = 1'b1;
            end
        end
    end

    assign comp_init = found;
    assign comp_data = ops[gidx];
    assign consume   = rsp_valid_q & rsp_ready_i;
    assign busy_d    = (busy_q | grant) & ~consume;

    ame_num_approx #(
        .DATA_BITS (DATA_BITS),
        .RES_BITS  (RES_BITS)
    ) u_approx (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .comp_init_i (comp_init),
        .comp_data_i (comp_data),
        .comp_data_o (comp_res)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_q         <= 1'b0;
            ptr_q         <= '0;
            busy_q        <= '0;
            busy_q_out    <= 1'b0;
            inflight_v    <= 1'b0;
            inflight_tag  <= '0;
            inflight_zero <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            busy_q     <= busy_d;
            busy_q_out <= |busy_d;
            inflight_v <= found;
            if (found) begin
                ptr_q         <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
                inflight_tag  <= gidx;
                inflight_zero <= (comp_data == '0);
            end
        end
    end

    // a slot never captures and drains in the same cycle: busy_q blocks re-issue
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_q <= '0;
            slot_data   <= '0;
            slot_zero   <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (inflight_v && (inflight_tag == PW'(i))) begin
                    rsp_valid_q[i] <= 1'b1;
                    slot_data[i]   <= inflight_zero ? '0 : comp_res;
                    slot_zero[i]   <= inflight_zero;
                end else if (consume[i]) begin
                    rsp_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign req_ready_o = grant;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = slot_data;
    assign rsp_zero_o  = slot_zero;
    assign busy_o      = busy_q_out;
endmodule

// File: tb/tb_ame_approx_arb.sv
// Bench for ame_approx_arb: directed grant/timing checks plus a per-requester
// scoreboard that pairs every accepted operand with its consumed result.
`timescale 1ns/1ps

module tb_ame_approx_arb;
    localparam int N  = 4;
    localparam int DB = 64;
    localparam int RB = 6;

    typedef struct packed {
        logic          zero;
        logic [RB-1:0] pos;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DB-1:0] req_data;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [N*RB-1:0] rsp_data;
    logic [N-1:0]    rsp_zero;
    logic            busy;

    int   ntests = 0;
    int   nfail  = 0;
    exp_t expq [N][$];

    ame_approx_arb #(.NUM_REQ(N), .DATA_BITS(DB), .RES_BITS(RB)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_data_i  (req_data),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_zero_o  (rsp_zero),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(logic [63:0] x);
        logic [63:0] m;
        exp_t e;
        m = x[63] ? (~x + 64'd1) : x;
        e.zero = (m == 64'd0);
        e.pos  = '0;
        for (int b = 63; b >= 0; b--) begin
            if (m[b]) begin
                e.pos = RB'(b);
                break;
            end
        end
        return e;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setop(int i, logic [63:0] v);
        req_data[i*DB +: DB] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) expq[i].delete();
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    function automatic logic [63:0] rand_op();
        logic [63:0] v;
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r == 0) v = 64'd0;
        else if (r == 1) v = 64'h8000_0000_0000_0000;
        else if (r == 2) v = 64'd1;
        else begin
            v = {$urandom, $urandom};
            v = v >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) v = -v;
        end
        return v;
    endfunction

    // scoreboard: push on accept, pop and compare on response handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i])
                    expq[i].push_back(model(req_data[i*DB +: DB]));
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (expq[i].size() == 0) begin
                        chk("rsp_unexpected", 64'(expq[i].size()), 64'd1);
                    end else begin
                        e = expq[i].pop_front();
                        chk("rsp_data", 64'(rsp_data[i*RB +: RB]), 64'(e.pos));
                        chk("rsp_zero", 64'(rsp_zero[i]), 64'(e.zero));
                    end
                end
            end
            chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            chk("ready_subset", 64'(req_ready & ~req_valid), 64'd0);
        end
    end

    initial begin
        int g0, g1, g2, g3, last, bad, waited, acc, cyc;
        bit found;
        logic [N-1:0] exp_rv [6];

        rst_n = 1'b0;
        req_valid = '1;
        rsp_ready = '0;
        req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_zero", 64'(rsp_zero), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // single request 0x100
        do_reset();
        setop(0, 64'h100);
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        chk("t1_busy_set", 64'(busy), 64'd1);
        chk("t1_rv_t1", 64'(rsp_valid), 64'd0);
        tick();
        chk("t1_rv_t2", 64'(rsp_valid), 64'b0001);
        chk("t1_data", 64'(rsp_data[0 +: RB]), 64'd8);
        chk("t1_zero", 64'(rsp_zero[0]), 64'd0);
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = '0;
        chk("t1_rv_clr", 64'(rsp_valid), 64'd0);
        chk("t1_busy_clr", 64'(busy), 64'd0);
        chk("t1_data_held", 64'(rsp_data[0 +: RB]), 64'd8);

        // all four at once
        do_reset();
        setop(0, 64'd1);
        setop(1, -64'sd5);
        setop(2, 64'd0);
        setop(3, 64'h8000_0000_0000_0000);
        req_valid = 4'b1111;
        exp_rv = '{4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("t2_ready", 64'(req_ready), (c < 4) ? 64'(1 << c) : 64'd0);
            chk("t2_rsp_valid", 64'(rsp_valid), 64'(exp_rv[c]));
            tick();
            if (c < 4) req_valid[c] = 1'b0;
        end
        chk("t2_data", 64'(rsp_data), {40'd0, 6'd63, 6'd0, 6'd2, 6'd0});
        chk("t2_zero", 64'(rsp_zero), 64'b0100);
        rsp_ready = 4'b1111;
        tick();
        rsp_ready = '0;
        #1;
        chk("t2_rv_clr", 64'(rsp_valid), 64'd0);
        chk("t2_busy_clr", 64'(busy), 64'd0);

        // requester 2 stalls on its response
        do_reset();
        setop(0, 64'd7);
        setop(1, -64'sd1);
        setop(2, 64'h1_0000);
        setop(3, 64'h7fff_ffff_ffff_ffff);
        req_valid = 4'b1111;
        rsp_ready = 4'b1011;
        g0 = 0; g1 = 0; g2 = 0; g3 = 0; bad = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (req_ready[0]) g0++;
            if (req_ready[1]) g1++;
            if (req_ready[2]) g2++;
            if (req_ready[3]) g3++;
            if (rsp_valid[2] && req_ready[2]) bad++;
            tick();
        end
        chk("t3_g2_once", 64'(g2), 64'd1);
        chk("t3_no_grant_held", 64'(bad), 64'd0);
        chk("t3_g0_min", 64'(g0 >= 5), 64'd1);
        chk("t3_g1_min", 64'(g1 >= 5), 64'd1);
        chk("t3_g3_min", 64'(g3 >= 5), 64'd1);
        chk("t3_held", 64'(rsp_valid[2]), 64'd1);
        chk("t3_held_data", 64'(rsp_data[2*RB +: RB]), 64'd16);
        rsp_ready[2] = 1'b1;
        #1;
        chk("t3_no_same_cycle", 64'(req_ready[2]), 64'd0);
        tick();
        rsp_ready[2] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (req_ready[2]) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("t3_regrant", 64'(found), 64'd1);
        tick();
        req_valid = '0;
        rsp_ready = '1;
        repeat (6) tick();
        chk("t3_drain_busy", 64'(busy), 64'd0);

        // fairness between two hungry requesters
        do_reset();
        setop(0, 64'd3);
        setop(1, 64'hffff_ffff_0000_0000);
        req_valid = 4'b0011;
        rsp_ready = 4'b0011;
        g0 = 0; g1 = 0; last = -1; bad = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (req_ready != '0) begin
                if (last == int'(req_ready[1])) bad++;
                last = int'(req_ready[1]);
                if (req_ready[0]) g0++;
                if (req_ready[1]) g1++;
            end
            tick();
        end
        chk("t4_alternate", 64'(bad), 64'd0);
        chk("t4_g0_min", 64'(g0 >= 30), 64'd1);
        chk("t4_g1_min", 64'(g1 >= 30), 64'd1);
        chk("t4_balance", 64'((g0 - g1) <= 1 && (g1 - g0) <= 1), 64'd1);
        req_valid = '0;
        repeat (6) tick();
        chk("t4_drain_busy", 64'(busy), 64'd0);

        // reset the cycle after an accept
        do_reset();
        setop(0, 64'h100);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        rst_n = 1'b0;
        #1;
        chk("t5_ready", 64'(req_ready), 64'd0);
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_rsp_data", 64'(rsp_data), 64'd0);
        chk("t5_rsp_zero", 64'(rsp_zero), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        for (int i = 0; i < N; i++) expq[i].delete();
        repeat (2) tick();
        req_valid = '0;
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rsp_valid != '0 || busy) bad++;
        end
        chk("t5_no_ghost", 64'(bad), 64'd0);
        req_valid = 4'b0011;
        waited = 0;
        #1;
        while (req_ready == '0 && waited < 6) begin
            tick();
            waited++;
        end
        chk("t5_first_grant", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        rsp_ready = '1;
        repeat (6) tick();

        // randomized operands and consumer back-pressure
        do_reset();
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                rsp_ready[i] = ($urandom_range(0, 1) == 1);
                setop(i, rand_op());
            end
            #1;
            acc += $countones(req_valid & req_ready);
            tick();
            cyc++;
        end
        chk("t6_ops_done", 64'(acc >= 10000), 64'd1);
        req_valid = '0;
        rsp_ready = '1;
        repeat (6) tick();
        for (int i = 0; i < N; i++)
            chk("t6_queue_empty", 64'(expq[i].size()), 64'd0);
        chk("t6_busy_clr", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/ame_approx_arb.md
Name: ame_approx_arb

Overview:
- Shares one `ame_num_approx` instance among NUM_REQ requesters.
- `ame_num_approx` is the 64-bit signed magnitude to leading-one-position unit. It has a fixed 1-cycle latency and a registered output.
- This block does round-robin arbitration, issues at most one operation per cycle, tracks the in-flight tag, and holds each result in a per-requester slot until the requester consumes it.
- Sits between the AME cost/scale engines and the approximator.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_BITS, 64, operand width. Fixed to the approximator width.
- RES_BITS, $clog2(DATA_BITS) = 6, result width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester operand valid
- req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_data_i  in  NUM_REQ*DATA_BITS  operands, requester i at bits [i*DATA_BITS +: DATA_BITS], two's complement
- rsp_valid_o  out  NUM_REQ  result slot i holds a result
- rsp_ready_i  in  NUM_REQ  requester i consumes its result
- rsp_data_o  out  NUM_REQ*RES_BITS  leading-one position of |operand|, slot i at [i*RES_BITS +: RES_BITS]
- rsp_zero_o  out  NUM_REQ  operand was exactly zero
- busy_o  out  1  any slot occupied or any operation in flight

Behaviour:
- Reset values: all state clears asynchronously.
  - req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_zero_o=0, busy_o=0.
  - RR pointer=0; in-flight valid=0.
  - Reset mid-operation discards in-flight and held results; no response is emitted for them.
- Per-requester state busy_q[i] is set on accept and cleared on response handshake. It covers both in-flight and held.
- Eligibility: elig[i] = req_valid_i[i] & ~busy_q[i]. At most one outstanding operation per requester.
- Arbitration is combinational round-robin over elig, starting at pointer p.
  - req_ready_o = one-hot grant g. If elig == 0, req_ready_o = 0.
  - On a grant to i, p <= (i+1) mod NUM_REQ. No grant: p holds.
  - req_ready_o[i] depends on req_valid_i[i]; requesters must not wait for ready before raising valid.
- Issue: in the accept cycle T, comp_init_i=1 and comp_data_i = req_data_i of the granted requester, both muxed combinationally.
  - Registered at T: inflight_v<=1, inflight_tag<=i, inflight_zero<=(operand==0).
- Capture: at cycle T+1 the approximator output is valid. At the end of T+1:
  - slot[tag].data <= (inflight_zero ? 0 : comp_data_o)
  - slot[tag].zero <= inflight_zero
  - rsp_valid_o[tag] <= 1
  - Consequence: rsp_valid_o[i] rises in cycle T+2.
- Throughput: one accept per cycle across all requesters. Back-to-back issues to different requesters pipeline with no bubble.
- Response: rsp_valid_o[i] & rsp_ready_i[i] in cycle C clears rsp_valid_o[i] and busy_q[i] at the end of C. The earliest re-accept for i is C+1.
  - rsp_data_o/rsp_zero_o stay stable while rsp_valid_o=1 and are held after consumption.
- Arithmetic:
  - Magnitude = negate if MSB set.
  - 0x8000_0000_0000_0000 has magnitude 2^63, result 63.
  - Result = index of the highest set bit of the magnitude.
  - Zero operand: data 0, zero flag 1. Operand 1: data 0, zero flag 0; rsp_zero_o distinguishes the two.
- Simultaneous events: a capture into slot j and a response handshake on slot k≠j in the same cycle are independent. Capture into slot j while j is being consumed cannot occur, because busy_q prevents it.
- busy_o = |busy_q, registered.

Test Plan:
- Reset, then req 0 valid with 0x100 at cycle T: req_ready_o=0001 at T; rsp_valid_o[0]=1 at T+2, rsp_data=8, zero=0; rsp_ready pulse clears it; busy_o returns to 0.
- All 4 requesters valid at once with 1, -5, 0, 0x8000_0000_0000_0000: grants 0,1,2,3 in consecutive cycles.
  - Results 0/0, 2/0, 0/1, 63/0 in slots 0..3, appearing in consecutive cycles.
- Requester 2 holds valid with rsp_ready_i[2]=0: exactly one accept.
  - No second grant to 2 while rsp_valid_o[2]=1.
  - Others continue to be granted round-robin; after consuming, req 2 is re-granted no earlier than the next cycle.
- Fairness: requesters 0 and 1 continuously valid, consuming immediately. Grants alternate 0,1,0,1 once busy clears; neither starves over 100 cycles.
- Assert rst_n_i low the cycle after accepting a request. All outputs are 0 immediately (asynchronous); no rsp_valid_o after reset release; the first grant goes to requester 0.
- Randomised: operands and rsp_ready with a scoreboard versus the reference model (magnitude MSB index, zero flag) and tag correctness over 10k operations.
